ci_master_sequencer: RTL

- Initiator side of the multicycle custom-instruction interface used by function_evaluation (clk_en/start/done/dataa/datab/datac/n/result).
- Accepts operand triples from an upstream valid/ready stream, issues one custom instruction per triple, and waits for done.
- Returns each result on a downstream valid/ready stream with the measured latency.
- Used as a standalone hardware driver for the CORDIC/function units in system tests, without a Nios II core.

---
 rtl/ci_master_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ci_master_sequencer.sv
// Initiator for the multicycle custom-instruction interface: accepts operand triples on a
// valid/ready stream, issues one instruction per triple, and returns the result and latency.
// Optional watchdog: define CI_TIMEOUT_EN to end a stalled WAIT after TIMEOUT_CYCLES.
module ci_master_sequencer #(
    parameter int DATA_W         = 32,
    parameter int N_W            = 2,
    parameter int LAT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [N_W-1:0]    in_n,

    output logic              ci_clk_en,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    output logic [DATA_W-1:0] ci_datab,
    output logic [DATA_W-1:0] ci_datac,
    output logic [N_W-1:0]    ci_n,
    input  logic              ci_done,
    input  logic [DATA_W-1:0] ci_result,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [LAT_W-1:0]  out_latency,
    output logic              out_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [DATA_W-1:0] r_dataa;
    logic [DATA_W-1:0] r_datab;
    logic [DATA_W-1:0] r_datac;
    logic [N_W-1:0]    r_n;
    logic [LAT_W-1:0]  r_lat;
    logic [DATA_W-1:0] r_out_result;
    logic [LAT_W-1:0]  r_out_latency;

    logic [LAT_W-1:0]  w_lat_inc;
    logic              w_accept;
    logic              w_done_hit;
    logic              w_timeout_hit;
    logic              w_out_hs;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_done_hit = (r_state == S_WAIT) && ci_done;
    assign w_out_hs   = (r_state == S_HOLD) && out_ready;

    // Saturate rather than wrap so a very slow slave can never report a short latency.
    assign w_lat_inc = (&r_lat) ? r_lat : r_lat + LAT_W'(1);

`ifdef CI_TIMEOUT_EN
    localparam logic [LAT_W-1:0]  TIMEOUT_LAT = LAT_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0] QNAN        = DATA_W'(32'h7FC0_0000);

    logic r_out_timeout;

    // A done arriving in the limit cycle wins, so the watchdog is masked by ci_done.
    assign w_timeout_hit = (r_state == S_WAIT) && !ci_done && (r_lat >= TIMEOUT_LAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_timeout <= 1'b0;
        end else if (w_done_hit) begin
            r_out_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_out_timeout <= 1'b1;
        end
    end

    assign out_timeout = r_out_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign out_timeout   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment on entry keeps this block purely combinational (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_done_hit || w_timeout_hit) w_next_state = S_HOLD;
            S_HOLD:  if (w_out_hs) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        ci_start  = 1'b0;
        ci_clk_en = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
            end
            S_ISSUE: begin
                ci_start  = 1'b1;
                ci_clk_en = 1'b1;
            end
            S_WAIT:  ci_clk_en = 1'b1;
            S_HOLD:  out_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Operands load only in IDLE, so they stay stable from ISSUE through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataa       <= '0;
            r_datab       <= '0;
            r_datac       <= '0;
            r_n           <= '0;
            r_lat         <= '0;
            r_out_result  <= '0;
            r_out_latency <= '0;
        end else begin
            if (w_accept) begin
                r_dataa <= in_a;
                r_datab <= in_b;
                r_datac <= in_c;
                r_n     <= in_n;
                r_lat   <= LAT_W'(1);
            end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
                r_lat <= w_lat_inc;
            end

            if (w_done_hit) begin
                r_out_result  <= ci_result;
                r_out_latency <= r_lat;
            end
`ifdef CI_TIMEOUT_EN
            else if (w_timeout_hit) begin
                r_out_result  <= QNAN;
                r_out_latency <= TIMEOUT_LAT;
            end
`endif
        end
    end

    assign ci_dataa    = r_dataa;
    assign ci_datab    = r_datab;
    assign ci_datac    = r_datac;
    assign ci_n        = r_n;
    assign out_result  = r_out_result;
    assign out_latency = r_out_latency;

endmodule
